// File: rtl/axi_pkt_mux_n.sv
// axi_pkt_mux_n: N-input AXI-stream packet multiplexer.
//
// Merges NUM_INPUTS AXI-stream inputs onto one output, switching only on
// packet boundaries. Arbitration is round-robin (PRIO=0) or strict priority
// with the lowest index winning (PRIO=1). BUFFER=1 adds a registered 2-entry
// skid stage on the output; BUFFER=0 passes the granted input straight through.
//
// Ports:
//   clk          single clock
//   reset_n      asynchronous active-low reset
//   clear        synchronous soft clear (same effect as reset)
//   i_tdata      concatenated input data, input k at [k*WIDTH +: WIDTH]
//   i_tlast      per-input end of packet
//   i_tvalid     per-input valid
//   i_tready     per-input ready (only the granted input, only while busy)
//   o_tdata      output data
//   o_tlast      output end of packet
//   o_tvalid     output valid
//   o_tready     output ready
//   active_port  granted input, meaningful while busy=1
//   busy         high while a packet is being forwarded
//   pkt_count    packets whose tlast beat left the output, wraps at 2^32
module axi_pkt_mux_n #(
  parameter int WIDTH      = 64,
  parameter int NUM_INPUTS = 4,
  parameter int PRIO       = 0,
  parameter int BUFFER     = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic [NUM_INPUTS*WIDTH-1:0]   i_tdata,
  input  logic [NUM_INPUTS-1:0]         i_tlast,
  input  logic [NUM_INPUTS-1:0]         i_tvalid,
  output logic [NUM_INPUTS-1:0]         i_tready,
  output logic [WIDTH-1:0]              o_tdata,
  output logic                          o_tlast,
  output logic                          o_tvalid,
  input  logic                          o_tready,
  output logic [$clog2(NUM_INPUTS)-1:0] active_port,
  output logic                          busy,
  output logic [31:0]                   pkt_count
);

  localparam int GW = $clog2(NUM_INPUTS);

  typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_t;

  state_t         state_q;
  logic [GW-1:0]  grant_q;
  logic [GW-1:0]  rr_ptr_q;
  logic [1:0]     rst_sync_q;
  logic [31:0]    pkt_count_q;
  logic [31:0]    pkt_count_d;

  logic [GW-1:0]  win;
  logic           found;
  logic [GW:0]    idx;
  logic [WIDTH-1:0] sel_data;
  logic           sel_last;
  logic           sel_valid;
  logic           in_vld;
  logic           in_fire;
  logic           dn_rdy;
  logic           arb_en;

  // Reset release is re-timed through two flops so arbitration never starts
  // on the edge where reset_n deasserts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign arb_en = rst_sync_q[1];

  // Winner selection. Round-robin searches upward from rr_ptr+1 with wrap;
  // the extra index bit keeps the sum from overflowing before the wrap.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    if (PRIO != 0) begin
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        if (i_tvalid[k]) win = GW'(k);
      end
    end else begin
      for (int k = 1; k <= NUM_INPUTS; k++) begin
        idx = {1'b0, rr_ptr_q} + (GW+1)'(k);
        if (idx >= (GW+1)'(NUM_INPUTS)) idx = idx - (GW+1)'(NUM_INPUTS);
        if (!found && i_tvalid[idx[GW-1:0]]) begin
          win   = idx[GW-1:0];
          found = 1'b1;
        end
      end
    end
  end

  // Granted-input select
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (grant_q == GW'(k)) begin
        sel_data  = i_tdata[k*WIDTH +: WIDTH];
        sel_last  = i_tlast[k];
        sel_valid = i_tvalid[k];
      end
    end
  end

  assign in_vld  = (state_q == PASS) && sel_valid;
  assign in_fire = in_vld && dn_rdy;

  always_comb begin
    i_tready = '0;
    if (state_q == PASS && dn_rdy) i_tready[grant_q] = 1'b1;
  end

  // Packet FSM: grant is latched in IDLE and held until the tlast beat is
  // accepted, so nothing can preempt a packet in flight. Returning to IDLE
  // after every packet gives the one-cycle arbitration bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= GW'(NUM_INPUTS - 1);
    end else if (clear) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= GW'(NUM_INPUTS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_en && (|i_tvalid)) begin
            grant_q <= win;
            state_q <= PASS;
          end
        end
        PASS: begin
          if (in_fire && sel_last) begin
            state_q <= IDLE;
            if (PRIO == 0) rr_ptr_q <= grant_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q == PASS);
  assign active_port = grant_q;

  generate
    if (BUFFER != 0) begin : g_skid
      logic             ov_q;
      logic             sk_v_q;
      logic             o_last_q;
      logic             sk_last_q;
      logic [WIDTH-1:0] o_data_q;
      logic [WIDTH-1:0] sk_data_q;

      // Upstream may push whenever the spare entry is empty; a beat arriving
      // while the head is stalled parks in the spare entry.
      assign dn_rdy = ~sk_v_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ov_q   <= 1'b0;
          sk_v_q <= 1'b0;
        end else if (clear) begin
          ov_q   <= 1'b0;
          sk_v_q <= 1'b0;
        end else if (!ov_q || o_tready) begin
          ov_q   <= sk_v_q | in_fire;
          sk_v_q <= 1'b0;
        end else if (in_fire) begin
          sk_v_q <= 1'b1;
        end
      end

      // Data path carries no reset; the valid flags above qualify it.
      always_ff @(posedge clk) begin
        if (!ov_q || o_tready) begin
          if (sk_v_q) begin
            o_data_q <= sk_data_q;
            o_last_q <= sk_last_q;
          end else if (in_fire) begin
            o_data_q <= sel_data;
            o_last_q <= sel_last;
          end
        end else if (in_fire) begin
          sk_data_q <= sel_data;
          sk_last_q <= sel_last;
        end
      end

      assign o_tvalid = ov_q;
      assign o_tdata  = o_data_q;
      assign o_tlast  = o_last_q;
    end else begin : g_pass
      assign dn_rdy   = o_tready;
      assign o_tvalid = in_vld;
      assign o_tdata  = sel_data;
      assign o_tlast  = sel_last;
    end
  endgenerate

  assign pkt_count_d = (o_tvalid && o_tready && o_tlast) ? pkt_count_q + 32'd1 : pkt_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count_q <= '0;
    end else if (clear) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  assign pkt_count = pkt_count_q;

endmodule

// File: doc/axi_pkt_mux_n.md
Name: axi_pkt_mux_n

Overview:
- Parametrised N-input AXI-stream packet multiplexer. It is the successor to the fixed four-input mux used on the radio RX and response paths.
- Adds selectable round-robin or strict-priority arbitration, strictly packet-atomic switching, an optional output skid register, and a forwarded-packet counter.
- Sits in the radio_clk domain ahead of the clock-crossing FIFOs, merging data, error and response streams onto one port.

Parameters:
- WIDTH, 64, tdata width per stream.
- NUM_INPUTS, 4, number of input streams, legal range 2..16.
- PRIO, 0: 0 = round-robin, 1 = strict priority (lowest index wins).
- BUFFER, 1: 1 = registered output skid stage at full throughput; 0 = combinational pass-through.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous soft clear.
- i_tdata  in  NUM_INPUTS*WIDTH  concatenated input data; input k occupies bits [k*WIDTH +: WIDTH].
- i_tlast  in  NUM_INPUTS  per-input end of packet.
- i_tvalid  in  NUM_INPUTS  per-input valid.
- i_tready  out  NUM_INPUTS  per-input ready.
- o_tdata  out  WIDTH  output data.
- o_tlast  out  1  output end of packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- active_port  out  clog2(NUM_INPUTS)  currently granted input; meaningful only while busy=1.
- busy  out  1  high while a packet is being forwarded (state PASS).
- pkt_count  out  32  count of packets whose tlast beat was accepted at the output; wraps modulo 2^32.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, grant=0, rr_ptr=NUM_INPUTS-1 (so input 0 wins first), skid register empty.
  - Outputs: o_tvalid=0, i_tready=0, busy=0, active_port=0, pkt_count=0.
  - Reset release is synchronised internally; the first transition out of IDLE is allowed no earlier than the second clk edge after release.
- clear: synchronous, same effect as reset (skid contents dropped, pkt_count zeroed). A packet in flight is truncated; upstream is responsible for flushing it.
- State IDLE:
  - All i_tready=0.
  - If any i_tvalid=1, arbitrate, register grant and go to PASS.
  - Arbitration takes exactly one cycle; no beat is transferred in IDLE.
- Arbitration, round-robin: winner is the first valid index searching rr_ptr+1, rr_ptr+2, … with wrap modulo NUM_INPUTS.
- Arbitration, strict: winner is the lowest valid index.
- State PASS:
  - i_tready[grant] = downstream-ready. For BUFFER=0 that is o_tready; for BUFFER=1 it is "skid not full".
  - All other i_tready=0.
  - A beat transfers when i_tvalid[grant] and i_tready[grant] are both high.
  - When the transferred beat has tlast=1: go to IDLE and set rr_ptr=grant (round-robin only).
  - No switch mid-packet, regardless of other inputs' valid or priority.
- Bubble: one idle cycle between consecutive packets, even when the next requester is already valid. This bubble is required behaviour.
- BUFFER=0: o_* are combinationally driven from input[grant] while in PASS; o_tvalid=0 in IDLE.
- BUFFER=1 (2-entry skid):
  - o_tvalid, o_tdata, o_tlast are registered.
  - Sustains one beat per cycle with o_tready=1.
  - Holds data stable while o_tready=0.
  - Latency: input beat to output is 1 cycle.
  - In IDLE, residual skid entries keep draining.
- pkt_count increments on o_tvalid & o_tready & o_tlast.
- Single-beat packets (tlast on the first beat) are legal: PASS lasts 1 cycle when ready.
- An input dropping tvalid mid-packet stalls the mux in PASS; grant is held.
- AXI rules: o_tvalid never deasserts without a handshake; o_tdata/o_tlast are stable while o_tvalid & !o_tready.

Test Plan:
- Reset/idle: hold reset_n=0 with all i_tvalid=1 -> o_tvalid=0, i_tready=0, pkt_count=0. Release -> first output beat comes from input 0.
- Round-robin fairness (PRIO=0, NUM_INPUTS=4): all four inputs continuously send 3-beat packets, o_tready=1 -> output port order 0,1,2,3,0…; exactly one bubble between packets; pkt_count=8 after 8 packets.
- Strict priority (PRIO=1): inputs 0 and 2 both valid, input 0 sends back-to-back packets -> input 2 is never granted until input 0 idles. Input 0 asserting valid mid-packet of input 2 does not preempt it.
- Backpressure (BUFFER=1): random o_tready (50%) with a 100-beat packet on input 1 -> all beats in order, none duplicated, o_tdata stable while stalled, tlast on beat 100.
- Single-beat packets on inputs 0 and 3 (NUM_INPUTS=4, round-robin) -> alternate grants; pkt_count increments by 1 per beat.
- Clear mid-packet after beat 5 of 10 -> next cycle o_tvalid=0, busy=0, pkt_count=0; the next arbitration starts from input 0.
